// File: rtl/ram_mm2s_reader.sv
// Command-driven sequential RAM reader streaming words out over AXI-Stream.
// Define READER_PERF_CNT_EN to add the stall_cnt output.
module ram_mm2s_reader #(
  parameter int AXI_WIDTH      = 128,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int LSB            = $clog2(AXI_WIDTH) - 3,
  parameter int LEN_WIDTH      = 16,
  parameter int DEPTH          = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [LEN_WIDTH-1:0]          cmd_beats,
  output logic                          mem_ren,
  output logic [AXI_ADDR_WIDTH-LSB-1:0] mem_addr,
  input  logic [AXI_WIDTH-1:0]          mem_data,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [AXI_WIDTH-1:0]          m_axis_tdata,
  output logic                          m_axis_tlast,
`ifdef READER_PERF_CNT_EN
  output logic [31:0]                   stall_cnt,
`endif
  output logic                          busy,
  output logic                          done
);

  localparam int WAW = AXI_ADDR_WIDTH - LSB;
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  state_t state, state_nx;

  logic [WAW-1:0]       waddr;
  logic [LEN_WIDTH-1:0] beats_left;
  logic                 inflight;
  logic                 inflight_last;
  logic [AXI_WIDTH:0]   fifo_mem [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 busy_q;
  logic                 done_q;
  logic                 accept;
  logic                 issue;
  logic                 push;
  logic                 pop;
  logic [CW:0]          occ;
  logic [AXI_WIDTH:0]   head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign accept = cmd_valid && cmd_ready;
  assign push   = inflight;
  assign pop    = m_axis_tvalid && m_axis_tready;
  // Occupancy seen by the next issue: stored + arriving - leaving.
  assign occ    = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign head   = fifo_mem[rd_ptr];

  assign cmd_ready     = (state == IDLE) && !rst;
  assign m_axis_tvalid = (count != '0);
  assign m_axis_tdata  = m_axis_tvalid ? head[AXI_WIDTH-1:0] : '0;
  assign m_axis_tlast  = m_axis_tvalid && head[AXI_WIDTH];
  assign mem_ren       = issue;
  assign mem_addr      = issue ? waddr : '0;
  assign busy          = busy_q;
  assign done          = done_q;

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept && cmd_beats != '0) state_nx = READ;
      end
      READ: begin
        if (occ < (CW+1)'(DEPTH)) begin
          issue = 1'b1;
          if (beats_left == LEN_WIDTH'(1)) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight && count == CW'(pop)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      waddr         <= '0;
      beats_left    <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state         <= state_nx;
      inflight      <= issue;
      inflight_last <= issue && (beats_left == LEN_WIDTH'(1));
      if (accept) begin
        waddr      <= cmd_addr[AXI_ADDR_WIDTH-1:LSB];
        beats_left <= cmd_beats;
      end else if (issue) begin
        waddr      <= waddr + WAW'(1);
        beats_left <= beats_left - LEN_WIDTH'(1);
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count  <= count + CW'(push) - CW'(pop);
      done_q <= (pop && m_axis_tlast) ||
                (accept && cmd_beats == '0);
      if (accept && cmd_beats != '0) busy_q <= 1'b1;
      else if (pop && m_axis_tlast) busy_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {inflight_last, mem_data};
  end

  always_ff @(posedge clk) begin
    if (!rst && push) assert (count < CW'(DEPTH));
  end

`ifdef READER_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else if (accept) stall_cnt <= '0;
    else if (m_axis_tvalid && !m_axis_tready && stall_cnt != '1)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ram_mm2s_reader.sv
// Self-checking bench for ram_mm2s_reader: vector table plus scoreboard.
module tb_ram_mm2s_reader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [31:0]  cmd_addr = '0;
  logic [15:0]  cmd_beats = '0;
  logic         mem_ren;
  logic [27:0]  mem_addr;
  logic [127:0] mem_data = '0;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b1;
  logic [127:0] m_axis_tdata;
  logic         m_axis_tlast;
  logic         busy;
  logic         done;
`ifdef READER_PERF_CNT_EN
  logic [31:0]  stall_cnt;
`endif

  int total = 0;
  int bad = 0;
  int n_pop = 0;
  int outst = 0;
  bit rdy_rnd = 1'b0;
  bit hold_v = 1'b0;
  logic [128:0] hold_d;
  logic [27:0]  addr_q[$];
  logic [128:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    int          beats;
    bit          rnd;
    bit          spam;
    logic [27:0] w0;
    int          cyc;
  } vec_t;

  vec_t vecs[6];

  ram_mm2s_reader dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_beats     (cmd_beats),
    .mem_ren       (mem_ren),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
`ifdef READER_PERF_CNT_EN
    .stall_cnt     (stall_cnt),
`endif
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mdata(input logic [27:0] w);
    logic [31:0] x;
    x = {4'h0, w};
    return {x, ~x, x * 32'd3 + 32'h1234, 32'hC0DE_0000 ^ x};
  endfunction

  task automatic chk(input string nm, input logic [128:0] act,
                     input logic [128:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // RAM model: 1-cycle read latency, junk when not reading
  always @(posedge clk)
    mem_data <= mem_ren ? mdata(mem_addr) : {4{$urandom}};

  always @(posedge clk) begin
    #1;
    if (rdy_rnd) m_axis_tready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (mem_ren) begin
        if (addr_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mem_ren_unexpected actual=%h required=none",
                   mem_addr);
        end else begin
          chk("mem_addr", mem_addr, addr_q.pop_front());
        end
        outst++;
      end
      if (hold_v) begin
        chk("tvalid_held", m_axis_tvalid, 1);
        chk("tdata_stable", {m_axis_tlast, m_axis_tdata}, hold_d);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat_unexpected actual=%h required=none",
                   m_axis_tdata);
        end else begin
          chk("beat", {m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
        end
        n_pop++;
        outst--;
      end
      if (mem_ren) chk("fifo_occ_le2", outst <= 2, 1);
      hold_v = m_axis_tvalid && !m_axis_tready;
      hold_d = {m_axis_tlast, m_axis_tdata};
    end
  end

  task automatic expect_cmd(input logic [27:0] w0, input int beats);
    logic [27:0] w;
    w = w0;
    for (int k = 0; k < beats; k++) begin
      addr_q.push_back(w);
      exp_q.push_back({k == beats - 1, mdata(w)});
      w = w + 28'd1;
    end
  endtask

  task automatic run_cmd(input vec_t v);
    int n;
    bit seen;
    expect_cmd(v.w0, v.beats);
    @(posedge clk);
    #1;
    rdy_rnd   = v.rnd;
    cmd_valid = 1'b1;
    cmd_addr  = v.addr;
    cmd_beats = 16'(v.beats);
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk);
    #1;
    if (v.spam) begin
      cmd_addr  = 32'h0000_8000;
      cmd_beats = 16'd9;
    end else begin
      cmd_valid = 1'b0;
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      if (v.spam && n <= 3) chk("cmd_ready_busy", cmd_ready, 0);
      if (v.beats == 0) chk("busy_zero", busy, 0);
      else if (done) chk("busy_at_done", busy, 0);
      else chk("busy_run", busy, 1);
      if (done) seen = 1'b1;
      if (v.spam && n == 3) begin
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
      end
    end
    chk("done_seen", seen, 1);
    if (v.cyc > 0) chk("done_cycle", n, v.cyc);
    @(negedge clk);
    chk("done_pulse_end", done, 0);
    chk("beats_left_over", exp_q.size(), 0);
    chk("reads_left_over", addr_q.size(), 0);
    rdy_rnd = 1'b0;
    m_axis_tready = 1'b1;
  endtask

  initial begin
    int n;
    int p0;
    vecs[0] = '{32'h0000_0100, 4, 1'b0, 1'b1, 28'h0000010, 7};
    vecs[1] = '{32'h0000_0200, 0, 1'b0, 1'b0, 28'h0000020, 1};
    vecs[2] = '{32'h0000_1000, 8, 1'b1, 1'b0, 28'h0000100, 0};
    vecs[3] = '{32'hFFFF_FFF0, 3, 1'b0, 1'b0, 28'hFFFFFFF, 6};
    vecs[4] = '{32'h0000_0037, 1, 1'b0, 1'b0, 28'h0000003, 4};
    vecs[5] = '{32'h0000_0500, 5, 1'b1, 1'b0, 28'h0000050, 0};

    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_ctl", {mem_ren, mem_addr, m_axis_tvalid, m_axis_tlast,
                    busy, done}, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1);

    for (int i = 0; i < 6; i++) run_cmd(vecs[i]);

    // abort mid-transfer after two beats have left
    expect_cmd(28'h0000030, 6);
    p0 = n_pop;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_0300;
    cmd_beats = 16'd6;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n = 0;
    while (n_pop - p0 < 2 && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("pops_before_rst", n_pop - p0, 2);
    rst = 1'b1;
    #1;
    chk("abort_ctl", {cmd_ready, mem_ren, mem_addr, m_axis_tvalid,
                      m_axis_tlast, busy, done}, 0);
    chk("abort_tdata", m_axis_tdata, 0);
    exp_q.delete();
    addr_q.delete();
    outst  = 0;
    hold_v = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);
    run_cmd('{32'h0000_0040, 2, 1'b0, 1'b0, 28'h0000004, 5});

`ifdef READER_PERF_CNT_EN
    expect_cmd(28'h0000060, 4);
    @(posedge clk);
    #1;
    m_axis_tready = 1'b0;
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_0600;
    cmd_beats = 16'd4;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_axis_tvalid && n < 20);
    chk("stall_tvalid", m_axis_tvalid, 1);
    repeat (5) @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 50);
    chk("stall_done", done, 1);
    chk("stall_cnt", stall_cnt, 5);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_mm2s_reader.md
Name: ram_mm2s_reader

Overview:
- Initiator side of the simple RAM read port (ren/addr/data, 1-cycle read latency) that the memory model services.
- Takes a command of word-aligned byte base address plus beat count, and issues sequential word reads.
- Returns the data as an AXI-Stream with full backpressure support. It feeds one mm2s channel of the array datapath.

Parameters:
- AXI_WIDTH, 128, data word width in bits; power of 2, ≥16.
- AXI_ADDR_WIDTH, 32, byte address width.
- LSB, $clog2(AXI_WIDTH)-3, derived; byte-offset bits dropped to form the word address.
- LEN_WIDTH, 16, beat-count width.
- DEPTH, 2, output FIFO entries; ≥2.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when valid&&ready.
- cmd_addr  in  AXI_ADDR_WIDTH  byte base address; low LSB bits ignored.
- cmd_beats  in  LEN_WIDTH  number of words to read.
- mem_ren  out  1  read enable to RAM.
- mem_addr  out  AXI_ADDR_WIDTH-LSB  word address.
- mem_data  in  AXI_WIDTH  read data, valid the cycle after mem_ren.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tdata  out  AXI_WIDTH  stream data.
- m_axis_tlast  out  1  high on final beat of command.
- busy  out  1  high from command accept until last beat handshaked.
- done  out  1  one-cycle pulse the cycle after the last beat handshake (or after accept if cmd_beats==0).

Behaviour:
- Reset values: cmd_ready=0 during rst and 1 after it releases (in IDLE). mem_ren=0, mem_addr=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, done=0. FIFO flushed, in-flight flag cleared.
- FSM IDLE -> READ -> DRAIN -> IDLE.
- IDLE: cmd_ready=1. On handshake, latch waddr=cmd_addr>>LSB and beats_left=cmd_beats, then go to READ. If cmd_beats==0: pulse done next cycle, stay IDLE, busy never asserted.
- READ: assert mem_ren with mem_addr=waddr when (fifo_count - pop + inflight) < DEPTH, where pop = tvalid&&tready this cycle and inflight is the ren from the previous cycle. Each issue does waddr+1 (wraps modulo 2^(AXI_ADDR_WIDTH-LSB)) and beats_left-1. Issue of the final beat goes to DRAIN.
- Read return: mem_data captured into FIFO the cycle after mem_ren. tlast is stored alongside, set on the beat issued with beats_left==1.
- DRAIN: no reads issued. When the FIFO is empty and nothing is in flight, go to IDLE, assert done one cycle, deassert busy.
- Stream output is FIFO head. tvalid is held and tdata/tlast are stable until tready (AXIS rule). Push and pop in the same cycle are allowed, and count is unchanged.
- Throughput: with tready held 1, one beat per cycle after 2-cycle startup (accept, ren, data visible in FIFO the next cycle).
- FIFO never overflows by construction. A write with the FIFO full is an assertion failure in simulation.
- cmd_valid while busy is ignored (cmd_ready=0).
- rst mid-transfer: immediate abort. Outputs return to reset values, and pending data is discarded.

Optional Feature:
- Macro READER_PERF_CNT_EN.
- Defined: adds output stall_cnt[31:0]. It counts cycles with m_axis_tvalid&&!m_axis_tready, clears on command accept and on rst, and saturates at 2^32-1.
- Undefined: port and counter are absent, and there is no other change.

Test Plan:
- cmd_addr=0x100, cmd_beats=4, AXI_WIDTH=128, tready=1 -> mem_addr 0x10,0x11,0x12,0x13 on consecutive cycles; 4 beats out back-to-back; tlast on 4th; done one cycle later.
- cmd_beats=0 -> no mem_ren; busy stays 0; done pulses once the cycle after accept.
- cmd_beats=8, tready toggles 1/0 randomly (50%) -> all 8 words in order, no drop/dup, tdata stable while stalled, and FIFO occupancy never >2.
- cmd_addr=0xFFFFFFF0, cmd_beats=3 -> mem_addr 0x0FFFFFFF, 0x0000000, 0x0000001 (wrap).
- rst asserted after 2 of 6 beats -> all outputs zero the same cycle; the subsequent command cmd_addr=0x40, beats=2 completes correctly.
- With READER_PERF_CNT_EN, cmd_beats=4, tready held 0 for 5 cycles then 1 -> stall_cnt=5 at done.
